vector_serializer: RTL and testbench
====================================

Name: vector_serializer

Overview:
- Parametrised successor to the single-element indexed register in the MLP datapath.
- Captures a full N_ELEM-element vector, e.g. a layer's activations or a weight row, into an internal buffer with a valid/ready handshake.
- Streams the vector one element per accepted beat, with its own internal index counter, so the MAC stage does not supply an external counter.
- Supports single-pass or repeat (wrap-around) mode, flush, and back-to-back vectors with no bubble.

Parameters:
- N_ELEM, 4, number of elements per vector (>=2).
- DATA_W, 16, signed element width in bits.
- IDX_W, $clog2(N_ELEM), index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  N_ELEM*DATA_W  packed vector; element k is bits [k*DATA_W +: DATA_W], signed.
- in_repeat  in  1  mode for this vector, sampled at accept: 1 = wrap continuously, 0 = single pass.
- flush  in  1  abort current vector, return to idle.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the current element.
- out_data  out  DATA_W  current element, signed, registered.
- out_index  out  IDX_W  index of out_data within the vector.
- out_last  out  1  out_index == N_ELEM-1.
- pass_count  out  16  completed passes of the current vector; saturates at 16'hFFFF.
- busy  out  1  state is STREAM.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything:
  - state=IDLE;
  - out_valid=0, out_data=0, out_index=0, out_last=0, pass_count=0, busy=0;
  - buffer contents don't-care.
- States are IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch in_data into the buffer, latch in_repeat into repeat_q, set idx=0, clear pass_count, go to STREAM.
  - Next cycle: out_valid=1, out_data=element 0, out_index=0.
  - Accept-to-first-element latency is 1 cycle.
- STREAM:
  - out_valid=1 and is held stable (data, index, last) until out_ready=1.
  - A beat is out_valid && out_ready. On a beat with idx<N_ELEM-1: idx+1, out_data updates next cycle.
  - Throughput is 1 element/cycle while out_ready=1.
  - Beat on the last element with repeat_q=1: idx wraps to 0, pass_count+1 (saturating), stay in STREAM.
  - Beat on the last element with repeat_q=0 and in_valid=1: back-to-back accept. Load the new vector, idx=0, pass_count=0, stay in STREAM, no bubble cycle.
  - Beat on the last element with repeat_q=0 and in_valid=0: go to IDLE, out_valid=0 next cycle, pass_count=1 held until the next accept.
- in_ready = IDLE || (STREAM && out_last && out_ready && !repeat_q && !flush).
  - This is the only combinational path from out_ready to in_ready.
  - in_ready is 0 in STREAM at all other times.
- flush (sampled at the clock edge, rst excepted, priority over all handshakes):
  - go to IDLE, out_valid=0 next cycle, idx=0;
  - pass_count is held;
  - no input accepted in that cycle.
  - flush in IDLE has no effect.
- Data is copied bit-exact; no arithmetic is applied to elements. Index arithmetic is modulo N_ELEM; idx never takes values >= N_ELEM, including non-power-of-2 N_ELEM.
- in_data is don't-care when not accepted. Changes to in_data after accept do not affect the streamed vector.
- busy is 1 exactly in STREAM.

Test Plan:
- Reset and single pass:
  - Stimulus: N_ELEM=4, DATA_W=16. Assert rst 2 cycles, then accept {-3,7,-32768,32767} with repeat=0; out_ready held 1.
  - Required: all outputs 0 after reset. out sequence -3,7,-32768,32767 on consecutive cycles starting 1 cycle after accept, indices 0..3, out_last only on 32767. Then IDLE, pass_count=1.
- Backpressure:
  - Stimulus: same vector; out_ready toggles 1,0,0,1,1,0,1.
  - Required: out_data/out_index stable while out_ready=0. All 4 elements appear exactly once, in order.
- Back-to-back:
  - Stimulus: vector A={1,2,3,4}, then in_valid held with B={5,6,7,8}.
  - Required: in_ready=0 during elements 1..3 and =1 only in the A last-beat cycle. Output 1..8 on 8 consecutive cycles with no gap.
- Repeat and flush:
  - Stimulus: repeat=1 vector {9,8,7}, N_ELEM=3; stream 7 beats, then flush.
  - Required: output 9,8,7,9,8,7,9. pass_count=2 after 6th beat. out_valid=0 the cycle after flush; in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst while idx=2 in STREAM, with in_valid=1 in the same cycle.
  - Required: the vector is not accepted. Next cycle IDLE, out_valid=0, out_index=0, pass_count=0.
- Non-power-of-2 wrap:
  - Stimulus: N_ELEM=5, repeat=1, 12 beats.
  - Required: out_index sequence 0,1,2,3,4,0,1,2,3,4,0,1; out_index is never 5..7.

Source files
------------

// File: rtl/vector_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_serializer
//  Description : Captures an N_ELEM-element signed vector with a valid/ready
//                handshake and streams it out one element per accepted beat,
//                using an internal index counter. Supports single-pass and
//                wrap-around repeat, flush, and bubble-free back-to-back
//                vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_serializer #(
   parameter  int N_ELEM = 4,
   parameter  int DATA_W = 16,
   localparam int IDX_W  = $clog2(N_ELEM)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_ELEM*DATA_W-1:0] in_data,
   input  logic                     in_repeat,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]         out_index,
   output logic                     out_last,
   output logic [15:0]              pass_count,
   output logic                     busy
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic                       repeat_q, repeat_d;
   logic [15:0]                pass_q, pass_d;
   logic signed [DATA_W-1:0]   data_q, data_d;
   logic signed [DATA_W-1:0]   buf_q [N_ELEM];

   logic                       at_last;
   logic                       beat;
   logic                       accept;
   logic [IDX_W-1:0]           idx_inc;
   logic [15:0]                pass_inc;

   // idx is forced back to 0 whenever the block leaves STREAM, so out_last
   // can be decoded from idx alone without also qualifying on state.
   assign at_last  = (idx_q == LAST_IDX);
   assign beat     = (state_q == S_STREAM) && out_ready;
   assign in_ready = (state_q == S_IDLE) ||
                     ((state_q == S_STREAM) && at_last && out_ready && !repeat_q && !flush);
   assign accept   = in_valid && in_ready;

   // Modulo-N_ELEM increment; explicit wrap keeps idx in range for any N_ELEM.
   assign idx_inc  = at_last ? '0 : idx_q + 1'b1;
   assign pass_inc = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;

   assign out_valid  = (state_q == S_STREAM);
   assign busy       = (state_q == S_STREAM);
   assign out_data   = data_q;
   assign out_index  = idx_q;
   assign out_last   = at_last;
   assign pass_count = pass_q;

   // Next-state logic: accept, advance, wrap, back-to-back reload and flush.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      repeat_d = repeat_q;
      pass_d   = pass_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_STREAM;
               idx_d    = '0;
               pass_d   = '0;
               repeat_d = in_repeat;
               data_d   = in_data[DATA_W-1:0];
            end
         end
         S_STREAM: begin
            if (flush) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (beat) begin
               idx_d  = idx_inc;
               data_d = buf_q[idx_inc];
               if (at_last) begin
                  pass_d = pass_inc;
                  if (!repeat_q) begin
                     if (accept) begin
                        // Next vector replaces this one with no idle cycle;
                        // element 0 comes straight from the input bus.
                        pass_d   = '0;
                        repeat_d = in_repeat;
                        data_d   = in_data[DATA_W-1:0];
                     end else begin
                        state_d = S_IDLE;
                     end
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         repeat_q <= 1'b0;
         pass_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         repeat_q <= repeat_d;
         pass_q   <= pass_d;
         data_q   <= data_d;
      end
   end

   // Vector buffer snapshot on accept; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < N_ELEM; k++) begin
            buf_q[k] <= in_data[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vector_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_serializer
//  Description : Self-checking bench for vector_serializer. Three instances
//                (N_ELEM = 4, 3, 5) share the stimulus bus; one is selected
//                at a time and compared against a beat-counting model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_serializer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        in_repeat;
   logic        flush;
   logic        out_ready;
   logic [79:0] in_data;
   int          sel;

   // N_ELEM = 4
   logic        ir0, ov0, ol0, b0;
   logic [15:0] od0, pc0;
   logic [1:0]  oi0;
   // N_ELEM = 3
   logic        ir1, ov1, ol1, b1;
   logic [15:0] od1, pc1;
   logic [1:0]  oi1;
   // N_ELEM = 5
   logic        ir2, ov2, ol2, b2;
   logic [15:0] od2, pc2;
   logic [2:0]  oi2;

   vector_serializer #(.N_ELEM(4), .DATA_W(16)) u_n4 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 0)), .in_ready(ir0),
      .in_data(in_data[63:0]), .in_repeat(in_repeat), .flush(flush && (sel == 0)),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_index(oi0),
      .out_last(ol0), .pass_count(pc0), .busy(b0));

   vector_serializer #(.N_ELEM(3), .DATA_W(16)) u_n3 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 1)), .in_ready(ir1),
      .in_data(in_data[47:0]), .in_repeat(in_repeat), .flush(flush && (sel == 1)),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_index(oi1),
      .out_last(ol1), .pass_count(pc1), .busy(b1));

   vector_serializer #(.N_ELEM(5), .DATA_W(16)) u_n5 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(ir2),
      .in_data(in_data[79:0]), .in_repeat(in_repeat), .flush(flush && (sel == 2)),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_index(oi2),
      .out_last(ol2), .pass_count(pc2), .busy(b2));

   // Outputs of the currently selected instance.
   logic        ir, ov, ol, bz;
   logic [15:0] od, pc;
   logic [2:0]  oi;

   always_comb begin
      ir = ir0; ov = ov0; ol = ol0; bz = b0; od = od0; pc = pc0; oi = {1'b0, oi0};
      case (sel)
         1: begin ir = ir1; ov = ov1; ol = ol1; bz = b1; od = od1; pc = pc1; oi = {1'b0, oi1}; end
         2: begin ir = ir2; ov = ov2; ol = ol2; bz = b2; od = od2; pc = pc2; oi = oi2; end
         default: ;
      endcase
   end

   // Reference model: a vector, a running count of beats since accept, and
   // the pass counter. Element index is simply beats modulo N.
   bit          m_act;
   bit          m_rep;
   int          m_pos;
   int          m_pass;
   int          mn;
   logic [15:0] mvec [5];

   int          n_cmp = 0;
   int          n_err = 0;

   bit          bp [7] = '{1, 0, 0, 1, 1, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mload(input bit rp, input logic [79:0] d);
      m_act  = 1'b1;
      m_rep  = rp;
      m_pos  = 0;
      m_pass = 0;
      for (int k = 0; k < mn; k++) mvec[k] = d[k*16 +: 16];
   endtask

   // One clock cycle: drive at the falling edge, compare, then advance model.
   task automatic cyc(input bit r, input bit v, input logic [79:0] d,
                      input bit rp, input bit fl, input bit rdy);
      int ei;
      bit last_e;
      bit ir_e;
      @(negedge clk);
      rst = r; in_valid = v; in_data = d; in_repeat = rp; flush = fl; out_ready = rdy;
      #1;
      ei     = m_pos % mn;
      last_e = m_act && (ei == mn - 1);
      ir_e   = !m_act || (last_e && rdy && !m_rep && !fl);
      chk("out_valid", {31'd0, ov}, {31'd0, m_act});
      chk("busy", {31'd0, bz}, {31'd0, m_act});
      chk("pass_count", {16'd0, pc}, m_pass);
      chk("in_ready", {31'd0, ir}, {31'd0, ir_e});
      if (m_act) begin
         chk("out_data", {16'd0, od}, {16'd0, mvec[ei]});
         chk("out_index", {29'd0, oi}, ei);
         chk("out_last", {31'd0, ol}, {31'd0, last_e});
         chk("index_range", {31'd0, (int'(oi) < mn)}, 32'd1);
      end
      if (r) begin
         m_act = 1'b0; m_pass = 0; m_pos = 0;
      end else if (!m_act) begin
         if (v) mload(rp, d);
      end else if (fl) begin
         m_act = 1'b0;
      end else if (rdy) begin
         m_pos++;
         if (m_pos % mn == 0) begin
            if (m_pass < 65535) m_pass++;
            if (!m_rep) begin
               if (v) mload(rp, d);
               else   m_act = 1'b0;
            end
         end
      end
   endtask

   // Reset every instance, then point the bench at another one.
   task automatic sw(input int s, input int n);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      sel = s;
      mn  = n;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [79:0] v1, va, vb, v3, rd;
      bit          rv, rr, rf, ry;

      sel = 0; mn = 4;
      rst = 1'b1; in_valid = 1'b0; in_repeat = 1'b0; flush = 1'b0; out_ready = 1'b1; in_data = '0;
      m_act = 1'b0; m_rep = 1'b0; m_pos = 0; m_pass = 0;
      for (int k = 0; k < 5; k++) mvec[k] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, ov}, 32'd0);
      chk("rst_out_data", {16'd0, od}, 32'd0);
      chk("rst_out_index", {29'd0, oi}, 32'd0);
      chk("rst_out_last", {31'd0, ol}, 32'd0);
      chk("rst_pass_count", {16'd0, pc}, 32'd0);
      chk("rst_busy", {31'd0, bz}, 32'd0);

      // Single pass with extreme values.
      v1 = {16'h0000, 16'h7FFF, 16'h8000, 16'h0007, 16'hFFFD};
      cyc(0, 1, v1, 0, 0, 1);
      repeat (6) cyc(0, 0, '0, 0, 0, 1);
      chk("single_pass_count", {16'd0, pc}, 32'd1);

      // Backpressure pattern.
      cyc(0, 1, v1, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, '0, 0, 0, bp[i]);
      repeat (4) cyc(0, 0, '0, 0, 0, 1);

      // Back-to-back vectors.
      va = {16'd0, 16'd4, 16'd3, 16'd2, 16'd1};
      vb = {16'd0, 16'd8, 16'd7, 16'd6, 16'd5};
      cyc(0, 1, va, 0, 0, 1);
      repeat (4) cyc(0, 1, vb, 0, 0, 1);
      repeat (5) cyc(0, 0, vb, 0, 0, 1);

      // Randomised traffic on the 4-element instance.
      for (int i = 0; i < 300; i++) begin
         rd = {$urandom(), $urandom(), $urandom()};
         rv = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 3) == 0);
         rf = m_act && ($urandom_range(0, 24) == 0);
         ry = ($urandom_range(0, 3) != 0);
         cyc(0, rv, rd, rr, rf, ry);
      end

      // Repeat mode and flush on the 3-element instance.
      sw(1, 3);
      v3 = {16'd0, 16'd0, 16'd0, 16'd7, 16'd8, 16'd9};
      cyc(0, 1, v3, 1, 0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, '0, 1, 0, 1);
      chk("repeat_pass_count", {16'd0, pc}, 32'd2);
      cyc(0, 0, '0, 0, 1, 1);
      cyc(0, 0, '0, 0, 0, 0);
      chk("flush_out_index", {29'd0, oi}, 32'd0);
      chk("flush_pass_held", {16'd0, pc}, 32'd2);

      // Reset in the middle of a vector, with a new vector offered.
      sw(0, 4);
      cyc(0, 1, v1, 0, 0, 1);
      repeat (2) cyc(0, 0, '0, 0, 0, 1);
      cyc(1, 1, va, 0, 0, 1);
      cyc(0, 0, '0, 0, 0, 0);
      chk("midrst_out_valid", {31'd0, ov}, 32'd0);
      chk("midrst_out_index", {29'd0, oi}, 32'd0);
      chk("midrst_pass_count", {16'd0, pc}, 32'd0);

      // Non-power-of-2 wrap on the 5-element instance, then random traffic.
      sw(2, 5);
      rd = {$urandom(), $urandom(), $urandom()};
      cyc(0, 1, rd, 1, 0, 1);
      repeat (12) cyc(0, 0, '0, 1, 0, 1);
      chk("wrap_pass_count", {16'd0, pc}, 32'd2);
      for (int i = 0; i < 300; i++) begin
         rd = {$urandom(), $urandom(), $urandom()};
         rv = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 3) == 0);
         rf = m_act && ($urandom_range(0, 24) == 0);
         ry = ($urandom_range(0, 3) != 0);
         cyc(0, rv, rd, rr, rf, ry);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
